// File: rtl/mem_access_unit.sv
// Multicycle load/store initiator for a word-wide, byte-addressed, big-endian data RAM.
// Performs read-modify-write for sub-word stores and lane extraction/extension for sub-word loads.
module mem_access_unit #(
    parameter int unsigned MEM_BYTES = 64
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_req,
    input  logic        i_we,
    input  logic [1:0]  i_size,
    input  logic        i_sext,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_err,
    output logic [31:0] o_rdata,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    output logic        o_mem_rw,
    input  logic [31:0] i_mem_rdata
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RD   = 3'd1;
    localparam logic [2:0] S_MRG  = 3'd2;
    localparam logic [2:0] S_WR   = 3'd3;
    localparam logic [2:0] S_WREL = 3'd4;
    localparam logic [2:0] S_DONE = 3'd5;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    logic [2:0]  r_state;
    logic        r_we;
    logic [1:0]  r_size;
    logic        r_sext;
    logic [1:0]  r_off;
    logic [31:0] r_wdata;
    logic        r_err;

    logic [32:0] w_last_byte;
    logic        w_bad;

    // Last byte touched by the word containing i_addr; 33 bits so the top word cannot wrap.
    assign w_last_byte = {1'b0, i_addr[31:2], 2'b00} + 33'd3;
    assign w_bad = (i_size == 2'b11)
                || ((i_size == SZ_HALF) && i_addr[0])
                || ((i_size == SZ_WORD) && (i_addr[1:0] != 2'b00))
                || (w_last_byte > (33'(MEM_BYTES) - 33'd1));

    function automatic logic [31:0] f_extract(input logic [31:0] word, input logic [1:0] size,
                                              input logic [1:0] off, input logic sext);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        case (off)
            2'd0:    b = word[31:24];
            2'd1:    b = word[23:16];
            2'd2:    b = word[15:8];
            default: b = word[7:0];
        endcase
        h = off[1] ? word[15:0] : word[31:16];
        case (size)
            SZ_BYTE: res = {{24{sext & b[7]}}, b};
            SZ_HALF: res = {{16{sext & h[15]}}, h};
            default: res = word;
        endcase
        return res;
    endfunction

    function automatic logic [31:0] f_merge(input logic [31:0] word, input logic [31:0] wd,
                                            input logic [1:0] size, input logic [1:0] off);
        logic [31:0] res;
        res = word;
        if (size == SZ_BYTE) begin
            case (off)
                2'd0:    res[31:24] = wd[7:0];
                2'd1:    res[23:16] = wd[7:0];
                2'd2:    res[15:8]  = wd[7:0];
                default: res[7:0]   = wd[7:0];
            endcase
        end else if (off[1]) begin
            res[15:0] = wd[15:0];
        end else begin
            res[31:16] = wd[15:0];
        end
        return res;
    endfunction

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_we        <= 1'b0;
            r_size      <= 2'b00;
            r_sext      <= 1'b0;
            r_off       <= 2'b00;
            r_wdata     <= '0;
            r_err       <= 1'b0;
            o_rdata     <= '0;
            o_mem_addr  <= '0;
            o_mem_wdata <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_req) begin
                        r_we    <= i_we;
                        r_size  <= i_size;
                        r_sext  <= i_sext;
                        r_off   <= i_addr[1:0];
                        r_wdata <= i_wdata;
                        if (w_bad) begin
                            r_err   <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_err      <= 1'b0;
                            o_mem_addr <= {i_addr[31:2], 2'b00};
                            if (i_we && (i_size == SZ_WORD)) begin
                                o_mem_wdata <= i_wdata;
                                r_state     <= S_MRG;
                            end else begin
                                r_state <= S_RD;
                            end
                        end
                    end
                end
                S_RD: begin
                    // Merged word is registered on the RD->MRG edge so the write word
                    // is already stable throughout MRG, WR and WREL.
                    if (r_we) begin
                        o_mem_wdata <= f_merge(i_mem_rdata, r_wdata, r_size, r_off);
                        r_state     <= S_MRG;
                    end else begin
                        o_rdata <= f_extract(i_mem_rdata, r_size, r_off, r_sext);
                        r_state <= S_DONE;
                    end
                end
                S_MRG:   r_state <= S_WR;
                S_WR:    r_state <= S_WREL;
                S_WREL:  r_state <= S_DONE;
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_busy   = (r_state != S_IDLE);
    assign o_done   = (r_state == S_DONE);
    assign o_err    = o_done & r_err;
    assign o_mem_rw = (r_state == S_WR);

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit with a behavioural 64-byte big-endian RAM.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [1:0]  size = 2'b00;
    logic        sext = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        busy, done, err, mem_rw;
    logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;

    logic [31:0] ram [0:15];
    int checks = 0;
    int failures = 0;
    int rw_cnt = 0;
    int stab_err = 0;
    logic        prev_rw = 1'b0;
    logic [31:0] prev_addr = '0;
    logic [31:0] prev_wdata = '0;

    mem_access_unit #(.MEM_BYTES(64)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_we(we), .i_size(size),
        .i_sext(sext), .i_addr(addr), .i_wdata(wdata), .o_busy(busy), .o_done(done),
        .o_err(err), .o_rdata(rdata), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
        .o_mem_rw(mem_rw), .i_mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    assign mem_rdata = ram[mem_addr[5:2]];

    // RAM write, rw pulse counting and address/data stability around rw edges, all mid-cycle.
    always @(negedge clk) begin
        if (mem_rw === 1'b1) begin
            ram[mem_addr[5:2]] = mem_wdata;
            rw_cnt = rw_cnt + 1;
        end
        if (rst_n === 1'b1 && mem_rw !== prev_rw
            && (mem_addr !== prev_addr || mem_wdata !== prev_wdata))
            stab_err = stab_err + 1;
        prev_rw = mem_rw;
        prev_addr = mem_addr;
        prev_wdata = mem_wdata;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (busy !== 1'b0 && n < 20) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic run_op(input string tag, input logic w, input logic [1:0] sz, input logic sx,
                          input logic [31:0] a, input logic [31:0] wd,
                          input int exp_lat, input logic exp_err, input int exp_rw);
        int lat = 0;
        int rw0;
        wait_idle();
        rw0 = rw_cnt;
        req = 1'b1; we = w; size = sz; sext = sx; addr = a; wdata = wd;
        do begin
            @(posedge clk);
            #1;
            lat++;
            req = 1'b0;
        end while (done !== 1'b1 && lat < 12);
        chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_err"}, {31'b0, err}, {31'b0, exp_err});
        chk({tag, "_rw"}, 32'(rw_cnt - rw0), 32'(exp_rw));
    endtask

    initial begin
        int first, second, ndone;
        logic seen;
        for (int i = 0; i < 16; i++) ram[i] = '0;
        ram[3]  = 32'h11223344;
        ram[15] = 32'h000000A5;

        #12;
        chk("rst_busy", {31'b0, busy}, 32'h0);
        chk("rst_done_err_rw", {29'b0, done, err, mem_rw}, 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        chk("rst_rdata", rdata, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("sw10", 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 4, 1'b0, 1);
        run_op("lw10", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 2, 1'b0, 0);
        chk("lw10_data", rdata, 32'hDEADBEEF);

        run_op("sb12", 1'b1, 2'b00, 1'b0, 32'h12, 32'hFFFFFF5A, 5, 1'b0, 1);
        run_op("lw10b", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 2, 1'b0, 0);
        chk("lw10b_data", rdata, 32'hDEAD5AEF);
        run_op("lb10", 1'b0, 2'b00, 1'b1, 32'h10, 32'h0, 2, 1'b0, 0);
        chk("lb10_data", rdata, 32'hFFFFFFDE);
        run_op("lbu13", 1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 2, 1'b0, 0);
        chk("lbu13_data", rdata, 32'h000000EF);
        run_op("lb3f", 1'b0, 2'b00, 1'b1, 32'h3F, 32'h0, 2, 1'b0, 0);
        chk("lb3f_data", rdata, 32'hFFFFFFA5);

        run_op("sh0e", 1'b1, 2'b01, 1'b0, 32'h0E, 32'h12348001, 5, 1'b0, 1);
        run_op("lw0c", 1'b0, 2'b10, 1'b0, 32'h0C, 32'h0, 2, 1'b0, 0);
        chk("lw0c_data", rdata, 32'h11228001);
        run_op("lh0e", 1'b0, 2'b01, 1'b1, 32'h0E, 32'h0, 2, 1'b0, 0);
        chk("lh0e_data", rdata, 32'hFFFF8001);
        run_op("lhu0e", 1'b0, 2'b01, 1'b0, 32'h0E, 32'h0, 2, 1'b0, 0);
        chk("lhu0e_data", rdata, 32'h00008001);

        run_op("err_lw02", 1'b0, 2'b10, 1'b0, 32'h02, 32'h0, 1, 1'b1, 0);
        run_op("err_lh05", 1'b0, 2'b01, 1'b0, 32'h05, 32'h0, 1, 1'b1, 0);
        run_op("err_sz11", 1'b1, 2'b11, 1'b0, 32'h00, 32'h0, 1, 1'b1, 0);
        run_op("err_lw40", 1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 1, 1'b1, 0);
        chk("err_rdata_kept", rdata, 32'h00008001);
        chk("err_addr_kept", mem_addr, 32'h0000000C);

        // req held high through a load: second acceptance right after the IDLE gap
        wait_idle();
        req = 1'b1; we = 1'b0; size = 2'b10; sext = 1'b0; addr = 32'h10;
        first = 0; second = 0;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
                if (first == 0) first = c;
                else if (second == 0) second = c;
            end
            if (second != 0) break;
        end
        req = 1'b0;
        chk("held_first_done", 32'(first), 32'd2);
        chk("held_second_done", 32'(second), 32'd5);
        chk("held_data", rdata, 32'hDEAD5AEF);

        // req pulsed while busy during a word store is ignored
        wait_idle();
        req = 1'b1; we = 1'b1; size = 2'b10; addr = 32'h08; wdata = 32'hCAFEF00D;
        ndone = 0;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk);
            #1;
            if (c == 1) req = 1'b0;
            if (c == 2) req = 1'b1;
            if (c == 3) req = 1'b0;
            if (done === 1'b1) ndone++;
        end
        chk("pulse_done_count", 32'(ndone), 32'd1);
        run_op("lw08", 1'b0, 2'b10, 1'b0, 32'h08, 32'h0, 2, 1'b0, 0);
        chk("lw08_data", rdata, 32'hCAFEF00D);

        // asynchronous reset during WR
        wait_idle();
        req = 1'b1; we = 1'b1; size = 2'b10; addr = 32'h20; wdata = 32'h12345678;
        seen = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk);
            #1;
            req = 1'b0;
            if (mem_rw === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        chk("wr_reached", {31'b0, seen}, 32'h1);
        rst_n = 1'b0;
        #1;
        chk("arst_rw_busy", {30'b0, mem_rw, busy}, 32'h0);
        chk("arst_done_err", {30'b0, done, err}, 32'h0);
        chk("arst_mem_addr", mem_addr, 32'h0);
        chk("arst_mem_wdata", mem_wdata, 32'h0);
        chk("arst_rdata", rdata, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op("post_rst_lw", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 2, 1'b0, 0);
        chk("post_rst_data", rdata, 32'hDEAD5AEF);

        chk("rw_stability", 32'(stab_err), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
